// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: takes coins up to a 40-unit cap, serves vend
// requests against the stored credit, and hands the balance to the hopper
// on cancel. Every output comes straight from a flop.
module coin_credit_accumulator (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [2:0] coin_code,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic [5:0] credit,
  input  logic       vend_req,
  input  logic [5:0] price,
  output logic       vend_grant,
  output logic       vend_deny,
  input  logic       cancel,
  output logic       refund_valid,
  output logic [5:0] refund_units,
  input  logic       refund_ack,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, REFUND} state_t;

  localparam logic [6:0] CAP = 7'd40;

  state_t     state_q, state_d;
  logic [5:0] credit_q, credit_d;
  logic [5:0] refund_units_q, refund_units_d;
  logic       refund_valid_q, refund_valid_d;
  logic       coin_accept_q, coin_accept_d;
  logic       coin_reject_q, coin_reject_d;
  logic       vend_grant_q, vend_grant_d;
  logic       vend_deny_q, vend_deny_d;
  logic       busy_q, busy_d;

  logic [2:0] coin_val;
  logic [6:0] coin_sum;
  logic       vend_blocked;

  // Decode denomination; zero value marks an invalid code.
  always_comb begin
    coin_val = 3'd0;
    case (coin_code)
      3'b001:  coin_val = 3'd1;
      3'b010:  coin_val = 3'd2;
      3'b011:  coin_val = 3'd4;
      default: coin_val = 3'd0;
    endcase
  end

  // Widened so the cap compare never sees a wrapped sum.
  assign coin_sum = {1'b0, credit_q} + {4'b0, coin_val};
  // A held vend_req is still high while its own response pulse is out;
  // skipping that cycle prevents a second deduction.
  assign vend_blocked = vend_grant_q | vend_deny_q;

  // Next-state and registered-output logic, priority cancel > coin > vend.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    refund_units_d = refund_units_q;
    refund_valid_d = refund_valid_q;
    coin_accept_d  = 1'b0;
    coin_reject_d  = 1'b0;
    vend_grant_d   = 1'b0;
    vend_deny_d    = 1'b0;
    case (state_q)
      REFUND: begin
        coin_reject_d = coin_valid;
        vend_deny_d   = vend_req & ~vend_blocked;
        if (refund_ack) begin
          credit_d       = 6'd0;
          refund_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        if (cancel && credit_q != 6'd0) begin
          // Coin on the same edge goes back; vend waits for the next cycle.
          state_d        = REFUND;
          refund_valid_d = 1'b1;
          refund_units_d = credit_q;
          coin_reject_d  = coin_valid;
        end else if (coin_valid) begin
          if (coin_val != 3'd0 && coin_sum <= CAP) begin
            coin_accept_d = 1'b1;
            credit_d      = coin_sum[5:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (vend_req && !vend_blocked) begin
          if (price != 6'd0 && credit_q >= price) begin
            vend_grant_d = 1'b1;
            credit_d     = credit_q - price;
          end else begin
            vend_deny_d  = 1'b1;
          end
        end
        if (state_d != REFUND)
          state_d = (credit_d == 6'd0) ? IDLE : CREDIT;
      end
    endcase
    busy_d = (state_d == REFUND);
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= 6'd0;
      refund_units_q <= 6'd0;
      refund_valid_q <= 1'b0;
      coin_accept_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      vend_grant_q   <= 1'b0;
      vend_deny_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      refund_units_q <= refund_units_d;
      refund_valid_q <= refund_valid_d;
      coin_accept_q  <= coin_accept_d;
      coin_reject_q  <= coin_reject_d;
      vend_grant_q   <= vend_grant_d;
      vend_deny_q    <= vend_deny_d;
      busy_q         <= busy_d;
    end
  end

  assign coin_accept  = coin_accept_q;
  assign coin_reject  = coin_reject_q;
  assign credit       = credit_q;
  assign vend_grant   = vend_grant_q;
  assign vend_deny    = vend_deny_q;
  assign refund_valid = refund_valid_q;
  assign refund_units = refund_units_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Table-driven bench for coin_credit_accumulator with an expected-result queue.
module tb_coin_credit_accumulator;

  logic       clk = 1'b0;
  logic       reset, coin_valid, vend_req, cancel, refund_ack;
  logic [2:0] coin_code;
  logic [5:0] price;
  logic       coin_accept, coin_reject, vend_grant, vend_deny, refund_valid, busy;
  logic [5:0] credit, refund_units;

  coin_credit_accumulator dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_code(coin_code),
    .coin_accept(coin_accept), .coin_reject(coin_reject), .credit(credit),
    .vend_req(vend_req), .price(price), .vend_grant(vend_grant), .vend_deny(vend_deny),
    .cancel(cancel), .refund_valid(refund_valid), .refund_units(refund_units),
    .refund_ack(refund_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, cv;
    logic [2:0] code;
    logic       vr;
    logic [5:0] pr;
    logic       cn, ack;
    logic       acc, rej, gr, dn;
    logic [5:0] cr;
    logic       rv;
    logic [5:0] ru;
    logic       bsy;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic rst, cv, input logic [2:0] code,
                              input logic vr, input logic [5:0] pr, input logic cn, ack,
                              input logic acc, rej, gr, dn, input logic [5:0] cr,
                              input logic rv, input logic [5:0] ru, input logic bsy);
    vec_t v;
    v.rst = rst; v.cv = cv; v.code = code; v.vr = vr; v.pr = pr; v.cn = cn; v.ack = ack;
    v.acc = acc; v.rej = rej; v.gr = gr; v.dn = dn; v.cr = cr; v.rv = rv; v.ru = ru; v.bsy = bsy;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL step%0d %s: got %0d want %0d", idx, nm, act, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    reset = v.rst; coin_valid = v.cv; coin_code = v.code; vend_req = v.vr;
    price = v.pr; cancel = v.cn; refund_ack = v.ack;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL step%0d queue: got empty want entry", idx);
      return;
    end
    e = exp_q.pop_front();
    check("coin_accept",  idx, int'(coin_accept),  int'(e.acc));
    check("coin_reject",  idx, int'(coin_reject),  int'(e.rej));
    check("vend_grant",   idx, int'(vend_grant),   int'(e.gr));
    check("vend_deny",    idx, int'(vend_deny),    int'(e.dn));
    check("credit",       idx, int'(credit),       int'(e.cr));
    check("refund_valid", idx, int'(refund_valid), int'(e.rv));
    check("busy",         idx, int'(busy),         int'(e.bsy));
    if (e.rv || e.rst)
      check("refund_units", idx, int'(refund_units), int'(e.ru));
  endtask

  initial begin
    reset = 1'b1; coin_valid = 1'b0; coin_code = 3'd0; vend_req = 1'b0;
    price = 6'd0; cancel = 1'b0; refund_ack = 1'b0;

    //             rst cv code  vr pr   cn ack  acc rej gr dn cr  rv ru bsy
    tbl.push_back(mk(1, 0, 3'd0, 0, 6'd0, 0, 0,  0, 0, 0, 0, 6'd0, 0, 6'd0, 0));
    tbl.push_back(mk(0, 1, 3'd3, 0, 6'd0, 0, 0,  1, 0, 0, 0, 6'd4, 0, 6'd0, 0));
    tbl.push_back(mk(0, 1, 3'd2, 0, 6'd0, 0, 0,  1, 0, 0, 0, 6'd6, 0, 6'd0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 0, 6'd0, 0, 0,  1, 0, 0, 0, 6'd7, 0, 6'd0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 1, 6'd6, 0, 0,  0, 0, 1, 0, 6'd1, 0, 6'd0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0, 6'd0, 0, 0,  0, 0, 0, 0, 6'd1, 0, 6'd0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 1, 6'd4, 0, 0,  0, 0, 0, 1, 6'd1, 0, 6'd0, 0));
    tbl.push_back(mk(0, 1, 3'd0, 0, 6'd0, 0, 0,  0, 1, 0, 0, 6'd1, 0, 6'd0, 0));
    tbl.push_back(mk(0, 1, 3'd7, 0, 6'd0, 0, 0,  0, 1, 0, 0, 6'd1, 0, 6'd0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 1, 6'd0, 0, 0,  0, 0, 0, 1, 6'd1, 0, 6'd0, 0));
    // coin beats vend; vend served next cycle with the new credit
    tbl.push_back(mk(0, 1, 3'd1, 1, 6'd2, 0, 0,  1, 0, 0, 0, 6'd2, 0, 6'd0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 1, 6'd2, 0, 0,  0, 0, 1, 0, 6'd0, 0, 6'd0, 0));
    // cancel with zero credit ignored
    tbl.push_back(mk(0, 0, 3'd0, 0, 6'd0, 1, 0,  0, 0, 0, 0, 6'd0, 0, 6'd0, 0));
    // held vend_req: one grant, then ignored while grant is high
    tbl.push_back(mk(0, 1, 3'd1, 0, 6'd0, 0, 0,  1, 0, 0, 0, 6'd1, 0, 6'd0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 1, 6'd1, 0, 0,  0, 0, 1, 0, 6'd0, 0, 6'd0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 1, 6'd1, 0, 0,  0, 0, 0, 0, 6'd0, 0, 6'd0, 0));
    // ack outside refund ignored
    tbl.push_back(mk(0, 0, 3'd0, 0, 6'd0, 0, 1,  0, 0, 0, 0, 6'd0, 0, 6'd0, 0));
    for (int i = 1; i <= 9; i++)
      tbl.push_back(mk(0, 1, 3'd3, 0, 6'd0, 0, 0, 1, 0, 0, 0, 6'(4*i), 0, 6'd0, 0));
    tbl.push_back(mk(0, 1, 3'd2, 0, 6'd0, 0, 0,  1, 0, 0, 0, 6'd38, 0, 6'd0, 0));
    tbl.push_back(mk(0, 1, 3'd3, 0, 6'd0, 0, 0,  0, 1, 0, 0, 6'd38, 0, 6'd0, 0));
    tbl.push_back(mk(0, 1, 3'd2, 0, 6'd0, 0, 0,  1, 0, 0, 0, 6'd40, 0, 6'd0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 0, 6'd0, 0, 0,  0, 1, 0, 0, 6'd40, 0, 6'd0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 1, 6'd35, 0, 0, 0, 0, 1, 0, 6'd5, 0, 6'd0, 0));
    // cancel + coin + vend together: coin back, refund 5, vend deferred
    tbl.push_back(mk(0, 1, 3'd1, 1, 6'd2, 1, 0,  0, 1, 0, 0, 6'd5, 1, 6'd5, 1));
    tbl.push_back(mk(0, 0, 3'd0, 1, 6'd2, 0, 0,  0, 0, 0, 1, 6'd5, 1, 6'd5, 1));
    tbl.push_back(mk(0, 0, 3'd0, 0, 6'd0, 0, 0,  0, 0, 0, 0, 6'd5, 1, 6'd5, 1));
    tbl.push_back(mk(0, 1, 3'd2, 0, 6'd0, 0, 0,  0, 1, 0, 0, 6'd5, 1, 6'd5, 1));
    tbl.push_back(mk(0, 0, 3'd0, 0, 6'd0, 0, 1,  0, 0, 0, 0, 6'd0, 0, 6'd0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0, 6'd0, 0, 0,  0, 0, 0, 0, 6'd0, 0, 6'd0, 0));

    foreach (tbl[i]) step(tbl[i], i);

    // Hand sequence: reset in the middle of a refund, with other inputs busy.
    step(mk(0, 1, 3'd3, 0, 6'd0, 0, 0,  1, 0, 0, 0, 6'd4, 0, 6'd0, 0), 100);
    step(mk(0, 0, 3'd0, 0, 6'd0, 1, 0,  0, 0, 0, 0, 6'd4, 1, 6'd4, 1), 101);
    step(mk(1, 1, 3'd1, 1, 6'd1, 1, 1,  0, 0, 0, 0, 6'd0, 0, 6'd0, 0), 102);
    step(mk(0, 0, 3'd0, 0, 6'd0, 0, 0,  0, 0, 0, 0, 6'd0, 0, 6'd0, 0), 103);
    step(mk(0, 1, 3'd1, 0, 6'd0, 0, 0,  1, 0, 0, 0, 6'd1, 0, 6'd0, 0), 104);

    // Hand sequence: reset while a vend is being answered.
    step(mk(0, 0, 3'd0, 1, 6'd1, 0, 0,  0, 0, 1, 0, 6'd0, 0, 6'd0, 0), 105);
    step(mk(0, 1, 3'd3, 0, 6'd0, 0, 0,  1, 0, 0, 0, 6'd4, 0, 6'd0, 0), 106);
    step(mk(1, 0, 3'd0, 1, 6'd2, 0, 0,  0, 0, 0, 0, 6'd0, 0, 6'd0, 0), 107);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
